uart_recv: RTL and testbench

UART_RECV -- requirements
Module: uart_recv

---
 rtl/uart_recv.sv | 210 +++++++++++++++++++++
 tb/tb_uart_recv.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/uart_recv.sv
`default_nettype none
// ============================================================================
// Module   : uart_recv
// Purpose  : Oversampling UART receiver with Hamming(8,4) SECDED decode and
//            nibble reassembly into a first-word-fall-through byte FIFO.
// Revision : 1.0  initial release
// ============================================================================
module uart_recv #(
   parameter int DATA_SIZE = 8,
   parameter int SIZE_FIFO = 16,
   parameter int SYS_FREQ  = 50000000,
   parameter int BAUD_RATE = 115200,
   parameter int SAMPLE    = 16,
   parameter int BAUD_DVSR = SYS_FREQ / (SAMPLE * BAUD_RATE)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rx,
   input  logic                 rd,
   input  logic                 clr_status,
   output logic [DATA_SIZE-1:0] bus_data_out,
   output logic                 rx_empty,
   output logic                 rx_full,
   output logic [3:0]           RX_status_register,
   output logic                 s_tick
);

   localparam int TW = (BAUD_DVSR > 1) ? $clog2(BAUD_DVSR) : 1;
   localparam int SW = (SAMPLE > 1) ? $clog2(SAMPLE) : 1;
   localparam int BW = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1;
   localparam int AW = $clog2(SIZE_FIFO);

   typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_t;

   logic [1:0]           r_sync;
   logic                 w_rx;
   logic [TW-1:0]        r_tcnt;
   state_t               r_state, w_state_nx;
   logic [SW-1:0]        r_scnt, w_scnt_nx;
   logic [BW-1:0]        r_bcnt, w_bcnt_nx;
   logic [DATA_SIZE-1:0] r_shift, w_shift_nx;
   logic                 w_cw_done, w_frame_err;

   always_ff @(posedge clk) begin
      if (reset) r_sync <= 2'b11;
      else       r_sync <= {r_sync[0], rx};
   end
   assign w_rx = r_sync[1];

   always_ff @(posedge clk) begin
      if (reset)                              r_tcnt <= '0;
      else if (r_tcnt == TW'(BAUD_DVSR - 1))  r_tcnt <= '0;
      else                                    r_tcnt <= r_tcnt + 1'b1;
   end
   assign s_tick = (r_tcnt == TW'(BAUD_DVSR - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_scnt  <= '0;
         r_bcnt  <= '0;
         r_shift <= '0;
      end else begin
         r_state <= w_state_nx;
         r_scnt  <= w_scnt_nx;
         r_bcnt  <= w_bcnt_nx;
         r_shift <= w_shift_nx;
      end
   end

   always_comb begin
      w_state_nx  = r_state;
      w_scnt_nx   = r_scnt;
      w_bcnt_nx   = r_bcnt;
      w_shift_nx  = r_shift;
      w_cw_done   = 1'b0;
      w_frame_err = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_rx) begin
               w_state_nx = START;
               w_scnt_nx  = '0;
            end
         end
         START: begin
            if (s_tick) begin
               if (r_scnt == SW'(SAMPLE / 2 - 1)) begin
                  w_scnt_nx  = '0;
                  w_bcnt_nx  = '0;
                  w_state_nx = w_rx ? IDLE : DATA;
               end else begin
                  w_scnt_nx = r_scnt + 1'b1;
               end
            end
         end
         DATA: begin
            if (s_tick) begin
               if (r_scnt == SW'(SAMPLE - 1)) begin
                  w_scnt_nx  = '0;
                  w_shift_nx = {w_rx, r_shift[DATA_SIZE-1:1]};
                  if (r_bcnt == BW'(DATA_SIZE - 1)) w_state_nx = STOP;
                  else                              w_bcnt_nx  = r_bcnt + 1'b1;
               end else begin
                  w_scnt_nx = r_scnt + 1'b1;
               end
            end
         end
         STOP: begin
            if (s_tick) begin
               if (r_scnt == SW'(SAMPLE - 1)) begin
                  w_state_nx  = IDLE;
                  w_cw_done   = w_rx;
                  w_frame_err = ~w_rx;
               end else begin
                  w_scnt_nx = r_scnt + 1'b1;
               end
            end
         end
         default: w_state_nx = IDLE;
      endcase
   end

   // Hamming(8,4) SECDED: syndrome locates a single flipped bit, overall parity
   // distinguishes single (correctable) from double (uncorrectable) errors.
   logic [7:0] w_cw, w_fix;
   logic [2:0] w_syn;
   logic       w_par, w_dbl, w_corr, w_good;
   logic [3:0] w_nib;

   assign w_cw  = r_shift[7:0];
   assign w_syn = {w_cw[4] ^ w_cw[5] ^ w_cw[6] ^ w_cw[3],
                   w_cw[1] ^ w_cw[2] ^ w_cw[5] ^ w_cw[6],
                   w_cw[0] ^ w_cw[2] ^ w_cw[4] ^ w_cw[6]};
   assign w_par = ^w_cw;

   always_comb begin
      w_fix = w_cw;
      if (w_par) begin
         if (w_syn == 3'd0) w_fix[7]            = ~w_cw[7];
         else               w_fix[w_syn - 3'd1] = ~w_cw[w_syn - 3'd1];
      end
   end

   assign w_nib  = {w_fix[6], w_fix[5], w_fix[4], w_fix[2]};
   assign w_dbl  = w_cw_done & ~w_par & (w_syn != 3'd0);
   assign w_corr = w_cw_done & w_par;
   assign w_good = w_cw_done & ~w_dbl;

   logic                 r_phase;
   logic [3:0]           r_low;
   logic                 r_wr_en;
   logic [DATA_SIZE-1:0] r_wr_data;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_phase   <= 1'b0;
         r_low     <= '0;
         r_wr_en   <= 1'b0;
         r_wr_data <= '0;
      end else begin
         r_wr_en <= 1'b0;
         if (w_frame_err || w_dbl) begin
            r_phase <= 1'b0;
         end else if (w_good) begin
            if (!r_phase) begin
               r_low   <= w_nib;
               r_phase <= 1'b1;
            end else begin
               r_wr_en   <= 1'b1;
               r_wr_data <= DATA_SIZE'({w_nib, r_low});
               r_phase   <= 1'b0;
            end
         end
      end
   end

   // FIFO pointers carry one extra wrap bit to separate full from empty.
   logic [DATA_SIZE-1:0] r_mem [SIZE_FIFO];
   logic [AW:0]          r_wptr, r_rptr;
   logic                 w_do_wr, w_do_rd, w_ovr;

   assign rx_empty = (r_wptr == r_rptr);
   assign rx_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign w_do_wr  = r_wr_en & (~rx_full | rd);
   assign w_do_rd  = rd & ~rx_empty;
   assign w_ovr    = r_wr_en & rx_full & ~rd;
   assign bus_data_out = rx_empty ? '0 : r_mem[r_rptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (w_do_wr) r_mem[r_wptr[AW-1:0]] <= r_wr_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (w_do_wr) r_wptr <= r_wptr + 1'b1;
         if (w_do_rd) r_rptr <= r_rptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) RX_status_register <= '0;
      else       RX_status_register <= (RX_status_register & {4{~clr_status}})
                                     | {w_ovr, w_dbl, w_corr, w_frame_err};
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_recv.sv
`default_nettype none
// Directed self-checking bench for uart_recv: clean, corrected, double-error,
// framing-error, FIFO overrun and mid-frame reset scenarios.
module tb_uart_recv;
   localparam int SYS  = 7372800;
   localparam int BAUD = 115200;
   localparam int SMP  = 16;
   localparam int DVSR = 4;
   localparam int BIT  = SMP * DVSR;

   logic       clk = 1'b0;
   logic       reset, rx, rd, clr_status;
   logic [7:0] bus_data_out;
   logic       rx_empty, rx_full, s_tick;
   logic [3:0] RX_status_register;

   int checks   = 0;
   int failures = 0;

   uart_recv #(
      .DATA_SIZE(8), .SIZE_FIFO(16), .SYS_FREQ(SYS), .BAUD_RATE(BAUD), .SAMPLE(SMP)
   ) dut (
      .clk(clk), .reset(reset), .rx(rx), .rd(rd), .clr_status(clr_status),
      .bus_data_out(bus_data_out), .rx_empty(rx_empty), .rx_full(rx_full),
      .RX_status_register(RX_status_register), .s_tick(s_tick)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] enc(input logic [3:0] d);
      logic [7:0] c;
      c[2] = d[0]; c[4] = d[1]; c[5] = d[2]; c[6] = d[3];
      c[0] = c[2] ^ c[4] ^ c[6];
      c[1] = c[2] ^ c[5] ^ c[6];
      c[3] = c[4] ^ c[5] ^ c[6];
      c[7] = ^c[6:0];
      return c;
   endfunction

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // A bad stop bit is held low just past its sampling point, then released
   // so the receiver sees the line recover before its start-bit check.
   task automatic send_cw(input logic [7:0] cw, input logic stop_ok);
      rx = 1'b0; idle(BIT);
      for (int i = 0; i < 8; i++) begin
         rx = cw[i]; idle(BIT);
      end
      if (stop_ok) begin
         rx = 1'b1; idle(2 * BIT);
      end else begin
         rx = 1'b0; idle(BIT * 11 / 16);
         rx = 1'b1; idle(2 * BIT - BIT * 11 / 16);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      send_cw(enc(b[3:0]), 1'b1);
      send_cw(enc(b[7:4]), 1'b1);
   endtask

   task automatic do_reset;
      reset = 1'b1; rx = 1'b1; rd = 1'b0; clr_status = 1'b0;
      idle(4);
      reset = 1'b0;
      idle(4);
   endtask

   task automatic pop;
      rd = 1'b1; idle(1);
      rd = 1'b0; idle(1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int ticks;
      logic [7:0] exp_b;

      @(negedge clk);
      reset = 1'b1; rx = 1'b1; rd = 1'b0; clr_status = 1'b0;
      idle(3);
      check("rst_empty",  32'(rx_empty), 32'd1);
      check("rst_full",   32'(rx_full), 32'd0);
      check("rst_data",   32'(bus_data_out), 32'h0);
      check("rst_status", 32'(RX_status_register), 32'h0);
      check("rst_tick",   32'(s_tick), 32'd0);
      reset = 1'b0;

      ticks = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (s_tick) ticks++;
      end
      check("tick_rate", 32'(ticks), 32'd10);

      // clean codewords
      do_reset();
      send_cw(8'h2D, 1'b1);
      send_cw(8'hD2, 1'b1);
      check("clean_data",   32'(bus_data_out), 32'hA5);
      check("clean_empty",  32'(rx_empty), 32'd0);
      check("clean_status", 32'(RX_status_register), 32'h0);

      // single-bit error corrected
      do_reset();
      send_cw(8'h29, 1'b1);
      send_cw(8'hD2, 1'b1);
      check("corr_data",   32'(bus_data_out), 32'hA5);
      check("corr_status", 32'(RX_status_register), 32'h2);
      clr_status = 1'b1; idle(1); clr_status = 1'b0; idle(1);
      check("clr_status",  32'(RX_status_register), 32'h0);

      // double error discarded
      do_reset();
      send_cw(8'h39, 1'b1);
      send_cw(8'h2D, 1'b1);
      send_cw(8'hD2, 1'b1);
      check("dbl_data",   32'(bus_data_out), 32'hA5);
      check("dbl_status", 32'(RX_status_register), 32'h4);
      pop();
      check("dbl_one_byte", 32'(rx_empty), 32'd1);

      // framing error discarded
      do_reset();
      send_cw(8'h2D, 1'b0);
      send_cw(8'h2D, 1'b1);
      send_cw(8'hD2, 1'b1);
      check("frm_data",   32'(bus_data_out), 32'hA5);
      check("frm_status", 32'(RX_status_register), 32'h1);
      pop();
      check("frm_one_byte", 32'(rx_empty), 32'd1);

      // overrun: 17 bytes into a 16-deep FIFO
      do_reset();
      for (int k = 0; k < 17; k++) send_byte(8'(k * 13 + 1));
      check("ovr_full",   32'(rx_full), 32'd1);
      check("ovr_status", 32'(RX_status_register), 32'h8);
      for (int k = 0; k < 16; k++) begin
         exp_b = 8'(k * 13 + 1);
         check($sformatf("ovr_pop%0d", k), 32'(bus_data_out), 32'(exp_b));
         pop();
      end
      check("ovr_drained", 32'(rx_empty), 32'd1);
      check("ovr_notfull", 32'(rx_full), 32'd0);

      // reset during the data bits of a codeword
      do_reset();
      rx = 1'b0; idle(BIT);
      rx = 1'b1; idle(BIT);
      rx = 1'b0; idle(BIT);
      rx = 1'b1; idle(BIT);
      reset = 1'b1; rx = 1'b1; idle(8);
      reset = 1'b0; idle(BIT);
      send_cw(8'h2D, 1'b1);
      send_cw(8'hD2, 1'b1);
      check("mrst_data",   32'(bus_data_out), 32'hA5);
      check("mrst_status", 32'(RX_status_register), 32'h0);
      pop();
      check("mrst_one_byte", 32'(rx_empty), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire
